// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the round-robin channel arbiters: state encodings,
// requester indexing and small helpers reused by multi-input variants.
package mux2_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam int NUM_REQ   = 2;
   localparam int REQ_IDX_W = 1;

   // Maps a requester index onto the state in which that requester owns the channel.
   function automatic arb_state_e owner_state(input logic [REQ_IDX_W-1:0] idx);
      return (idx == 1'b1) ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/mux2_bus.sv
// DATA_W-wide 2:1 multiplexer assembled bit by bit from the gate-level 2:1 mux.
module mux2_bus #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] I0,
   input  logic [DATA_W-1:0] I1,
   input  logic              S,
   output logic [DATA_W-1:0] Y
);

   for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      assign Y[i] = (I0[i] & ~S) | (I1[i] & S);
   end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin, hold-limited arbiter driving the select of a shared 2:1 mux
// channel and registering the selected data with a valid flag.
module mux2_rr_arbiter
   import mux2_rr_arbiter_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic [DATA_W-1:0] din0,
   input  logic [DATA_W-1:0] din1,
   output logic              grant0,
   output logic              grant1,
   output logic              sel,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid
);

   localparam int CNT_W = $clog2(MAX_HOLD) + 1;
   localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic [DATA_W-1:0] mux_y;
   logic              hold_at_limit;
   logic              owning;

   assign hold_at_limit = (hold_cnt_q == HOLD_LIMIT);
   assign owning        = (state_q == OWN0) || (state_q == OWN1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         hold_cnt_q   <= '0;
         last_q       <= 1'b1;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         last_q       <= last_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   // A releasing owner hands over directly when the other side waits; a
   // contended owner yields once its hold budget is spent.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req0 && req1)  state_d = owner_state(~last_q);
            else if (req0)     state_d = OWN0;
            else if (req1)     state_d = OWN1;
         end
         OWN0: begin
            if (!req0)                      state_d = req1 ? OWN1 : IDLE;
            else if (req1 && hold_at_limit) state_d = OWN1;
         end
         OWN1: begin
            if (!req1)                      state_d = req0 ? OWN0 : IDLE;
            else if (req0 && hold_at_limit) state_d = OWN0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      last_d     = last_q;
      if (state_d != state_q) begin
         hold_cnt_d = '0;
      end else if (owning && !hold_at_limit) begin
         hold_cnt_d = hold_cnt_q + 1'b1;
      end
      if (state_d == OWN0) last_d = 1'b0;
      if (state_d == OWN1) last_d = 1'b1;
   end

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      sel    = 1'b0;
      unique case (state_q)
         OWN0: grant0 = 1'b1;
         OWN1: begin
            grant1 = 1'b1;
            sel    = 1'b1;
         end
         default: ;
      endcase
   end

   mux2_bus #(.DATA_W(DATA_W)) u_mux (
      .I0 (din0),
      .I1 (din1),
      .S  (sel),
      .Y  (mux_y)
   );

   // Idle cycles keep the last transferred word but mark it stale.
   always_comb begin
      dout_d       = owning ? mux_y : dout_q;
      dout_valid_d = owning;
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Randomised and directed bench for mux2_rr_arbiter against an owner/hold-count
// reference model of the arbitration rules.
module tb_mux2_rr_arbiter;

   localparam int DATA_W   = 8;
   localparam int MAX_HOLD = 4;

   logic              clk;
   logic              rst_n;
   logic              req0, req1;
   logic [DATA_W-1:0] din0, din1;
   logic              grant0, grant1, sel, dout_valid;
   logic [DATA_W-1:0] dout;

   int vectors;
   int miscompares;

   int                m_owner;
   int                m_held;
   int                m_last;
   logic [DATA_W-1:0] m_dout;
   logic              m_valid;

   mux2_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .req1       (req1),
      .din0       (din0),
      .din1       (din1),
      .grant0     (grant0),
      .grant1     (grant1),
      .sel        (sel),
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".grant0"}, 32'(grant0), 32'(m_owner == 0));
      checkOutput({tag, ".grant1"}, 32'(grant1), 32'(m_owner == 1));
      checkOutput({tag, ".sel"}, 32'(sel), 32'(m_owner == 1));
      checkOutput({tag, ".dout"}, 32'(dout), 32'(m_dout));
      checkOutput({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
   endtask

   task automatic modelReset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 1;
      m_dout  = '0;
      m_valid = 1'b0;
   endtask

   // Owner keeps the channel for m_held grant cycles; contention ends it at MAX_HOLD.
   task automatic modelStep(input logic r0, input logic r1,
                            input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
      int  nxt;
      logic rx, ry;
      if (m_owner >= 0) begin
         m_dout  = (m_owner == 1) ? d1 : d0;
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      if (m_owner < 0) begin
         if (r0 && r1)  nxt = 1 - m_last;
         else if (r0)   nxt = 0;
         else if (r1)   nxt = 1;
         else           nxt = -1;
      end else begin
         rx = (m_owner == 1) ? r1 : r0;
         ry = (m_owner == 1) ? r0 : r1;
         if (!rx)                          nxt = ry ? 1 - m_owner : -1;
         else if (ry && m_held >= MAX_HOLD) nxt = 1 - m_owner;
         else                              nxt = m_owner;
      end
      if (nxt < 0) begin
         m_held = 0;
      end else if (nxt != m_owner) begin
         m_held = 1;
         m_last = nxt;
      end else begin
         m_held++;
      end
      m_owner = nxt;
   endtask

   task automatic applyStimulus(input logic r0, input logic r1,
                                input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                                input string tag);
      @(negedge clk);
      req0 = r0;
      req1 = r1;
      din0 = d0;
      din1 = d1;
      @(posedge clk);
      modelStep(r0, r1, d0, d1);
      #1;
      checkAll(tag);
   endtask

   task automatic doReset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      req0  = 1'b1;
      req1  = 1'b1;
      modelReset();
      #1;
      checkAll({tag, ".async"});
      repeat (2) begin
         @(posedge clk);
         #1;
         checkAll({tag, ".held"});
      end
      @(negedge clk);
      rst_n = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
   endtask

   initial begin
      logic r0, r1;
      vectors     = 0;
      miscompares = 0;
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      din0  = '0;
      din1  = '0;
      modelReset();

      doReset("reset");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, "idle");

      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'hA5, 8'h11, "single");
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 8'hA5, 8'h11, "single_drop");

      doReset("tie_reset");
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 8'(i), 8'(i + 8'h80), "tie");
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, "tie_end");

      doReset("early_reset");
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 8'h5A, 8'h3C, "early_both");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h5A, 8'h3C, "early_handoff");
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h3C, "early_end");

      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 8'h00, 8'(8'h40 + i), "solo1");
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 8'hC3, 8'h3C, "solo1_contend");

      // Reset asserted between edges while requester 1 owns the channel.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h01, 8'h77, "pre_async");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      modelReset();
      #1;
      checkAll("midgrant_reset");
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'hE1, 8'h1E, "post_reset_tie");

      r0 = 1'b0;
      r1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) r0 = ~r0;
         if ($urandom_range(3) == 0) r1 = ~r1;
         applyStimulus(r0, r1, 8'($urandom), 8'($urandom), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Shares one DATA_W-wide 2:1 mux output channel between two requesters (requester 0 on input I0, requester 1 on input I1).
- Decides who owns the channel using round-robin order and a hold limit.
- Drives the mux select and presents the selected data registered at the output with a valid flag.
- Sits directly in front of the gate-level 2:1 mux datapath as its sequencing and arbitration controller.

Parameters:
- DATA_W, 8, width of each data input and of dout.
- MAX_HOLD, 4, grant cycles after which the owner is pre-empted if the other requester is waiting; must be >= 1.
- CNT_W, $clog2(MAX_HOLD)+1, width of the hold counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 wants the channel; held high for the whole transfer
- req1  input  1  requester 1 wants the channel
- din0  input  DATA_W  requester 0 data (mux I0)
- din1  input  DATA_W  requester 1 data (mux I1)
- grant0  output  1  requester 0 owns the channel
- grant1  output  1  requester 1 owns the channel
- sel  output  1  mux select (S); 1 selects din1
- dout  output  DATA_W  registered mux output (Y)
- dout_valid  output  1  dout holds data sampled under a grant

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, grant0=0, grant1=0, sel=0, dout=0, dout_valid=0, hold_cnt=0, last=1 (requester 0 wins the first tie). Assertion clears everything immediately, with no clock edge needed, including mid-grant.
- States: IDLE, OWN0, OWN1.
- Decoded outputs:
  - grant0 = (state==OWN0); grant1 = (state==OWN1).
  - sel = 1 only in OWN1, else 0.
  - All are decoded from registers; no combinational path from req to grant.
- IDLE transitions:
  - req0 & !req1 -> OWN0.
  - req1 & !req0 -> OWN1.
  - Both high -> OWN(!last).
  - Neither -> stay in IDLE.
- OWNx transitions (y = the other requester):
  - !reqx & reqy -> OWNy directly, with no idle gap.
  - !reqx & !reqy -> IDLE.
  - reqx & reqy & hold_cnt==MAX_HOLD-1 -> OWNy (pre-emption).
  - Otherwise stay.
- Grant latency: a req sampled at edge n gives the grant high from edge n. The owner drops req at edge n, so the grant is low after edge n (one cycle of grant after the last req-high cycle is not permitted; the transition uses the registered req sample).
- last: updated to x on every entry to OWNx.
- hold_cnt:
  - Cleared on every state change.
  - Increments each cycle spent in OWNx.
  - Saturates at MAX_HOLD-1.
  - Under contention the owner therefore gets exactly MAX_HOLD grant cycles.
  - With no contention it keeps the channel indefinitely.
- MAX_HOLD=1: under continuous contention the grant alternates every cycle.
- Datapath:
  - Each edge in OWNx: dout <= (sel ? din1 : din0), dout_valid <= 1.
  - In IDLE: dout holds its value, dout_valid <= 0.
  - Data present during a grant cycle appears on dout one cycle later.
- Invariants: grant0 and grant1 are never high together; sel never changes while dout_valid refers to the old owner without a state change.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and a requester-index constant, reused by future multi-input arbiters.
- One sub-module: mux2_bus, a combinational DATA_W-wide 2:1 mux (inputs I0, I1, S; output Y) built per bit from the gate-level 2:1 mux. Its output feeds the dout register.

Test Plan:
- Reset: hold rst_n=0 with req0=req1=1 -> all outputs 0. Release with no requests -> grants stay 0 for 10 cycles.
- Single requester: din0=8'hA5, req0 high for 3 cycles -> grant0 high for those 3 cycles, sel=0, dout=8'hA5 with dout_valid=1 one cycle after each grant cycle; then grant0=0 and dout_valid=0.
- Tie and round-robin: req0=req1=1 continuously from reset, MAX_HOLD=4 -> grant0 for 4 cycles, grant1 for 4, repeating; sel toggles every 4 cycles; never both grants high.
- Early release: req0 held 2 cycles while req1 is pending -> grant1 asserts on the cycle after req0 drops, with no IDLE cycle; dout switches to din1=8'h3C.
- No contention: req1 alone for 20 cycles -> grant1 high all 20 cycles, no pre-emption, hold_cnt saturated at 3.
- Async reset mid-grant: drop rst_n between clock edges during OWN1 -> grant1, sel and dout_valid fall immediately. After release, a simultaneous request grants requester 0 first.
